// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: shared mode encoding, colour constants and the box
// reflection helper used by the pattern generator.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  // Colour words are {B, G, R}
  localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COLOR_YELLOW  = 24'h00FFFF;
  localparam logic [23:0] COLOR_CYAN    = 24'hFFFF00;
  localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
  localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COLOR_RED     = 24'h0000FF;
  localparam logic [23:0] COLOR_BLUE    = 24'hFF0000;
  localparam logic [23:0] COLOR_BLACK   = 24'h000000;

  localparam logic [23:0] BOX_FG = 24'hFFFFFF;
  localparam logic [23:0] BOX_BG = 24'h400000;
  localparam logic [7:0]  GRAD_B = 8'h80;

  // Bar colour by bar index, left (0) to right (7)
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = COLOR_WHITE;
      3'd1:    c = COLOR_YELLOW;
      3'd2:    c = COLOR_CYAN;
      3'd3:    c = COLOR_GREEN;
      3'd4:    c = COLOR_MAGENTA;
      3'd5:    c = COLOR_RED;
      3'd6:    c = COLOR_BLUE;
      default: c = COLOR_BLACK;
    endcase
    return c;
  endfunction

  // One box step on one axis: reflect at a wall first, then move 1 px.
  // Returns {new_forward, new_pos}; forward=1 means increasing position.
  function automatic logic [11:0] bounce_step(input logic [10:0] pos,
                                              input logic        fwd,
                                              input logic [10:0] lim);
    logic        f;
    logic [10:0] p;
    f = fwd;
    if (fwd && (pos == lim)) begin
      f = 1'b0;
    end else if (!fwd && (pos == 11'd0)) begin
      f = 1'b1;
    end
    p = f ? (pos + 11'd1) : (pos - 11'd1);
    return {f, p};
  endfunction

endpackage

// File: rtl/pattern_gen_btn.sv
// btn_debounce: 2-flop synchroniser, stable-level debounce counter and a
// one-cycle press pulse on each accepted 1->0 transition of the button.
module btn_debounce
  import pattern_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1350000
) (
  input  logic pix_clk,
  input  logic hdmi4_rst_n,
  input  logic I_btn_n,
  output logic O_press
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised level differs from the
  // accepted level; any bounce back clears the count.
  always_comb begin
    sync1_d = I_btn_n;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; the button idles high so the synchroniser resets to 1
  always_ff @(posedge pix_clk or negedge hdmi4_rst_n) begin
    if (!hdmi4_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign O_press = press_q;

endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: test pattern source for the HDMI controller, 4-cycle latency
// from counters to colour. Build macro PATTERN_GEN_BORDER_EN adds a white
// 1-px border around the active area in every mode.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int H_START         = 260,
  parameter int V_START         = 25,
  parameter int H_RES           = 1280,
  parameter int V_RES           = 720,
  parameter int BOX             = 64,
  parameter int DEBOUNCE_CYCLES = 1350000
) (
  input  logic        pix_clk,
  input  logic        hdmi4_rst_n,
  input  logic [11:0] I_hor_cnt,
  input  logic [11:0] I_ver_cnt,
  input  logic        I_btn_n,
  output logic [23:0] O_color,
  output logic [1:0]  O_mode
);

  localparam logic [11:0] H_FIRST   = 12'(H_START);
  localparam logic [11:0] H_LAST    = 12'(H_START + H_RES - 1);
  localparam logic [11:0] V_FIRST   = 12'(V_START);
  localparam logic [11:0] V_LAST    = 12'(V_START + V_RES - 1);
  localparam logic [10:0] BOX_X_MAX = 11'(H_RES - BOX);
  localparam logic [10:0] BOX_Y_MAX = 11'(V_RES - BOX);
  localparam logic [11:0] BOX_LEN   = 12'(BOX);
  localparam int          BAR_W     = H_RES / 8;

  logic        press;
  logic        frame_tick;
  mode_e       mode_q, mode_d, pending_q, pending_d;
  logic [10:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic        box_dx_q, box_dx_d, box_dy_q, box_dy_d;

  logic        s1_active_q, s1_active_d;
  logic [10:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;

  logic [23:0] s2_bars_q, s2_bars_d, s2_grad_q, s2_grad_d;
  logic [23:0] s2_check_q, s2_check_d, s2_box_q, s2_box_d;
  logic        s2_active_q, s2_active_d;
  mode_e       s2_mode_q, s2_mode_d;
`ifdef PATTERN_GEN_BORDER_EN
  logic        s2_edge_q, s2_edge_d;
`endif

  logic [23:0] s3_color_q, s3_color_d, out_color_q, out_color_d;
  logic [2:0]  bar_idx;
  logic        in_box_x, in_box_y;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .pix_clk    (pix_clk),
    .hdmi4_rst_n(hdmi4_rst_n),
    .I_btn_n    (I_btn_n),
    .O_press    (press)
  );

  assign frame_tick = (I_hor_cnt == 12'd0) && (I_ver_cnt == 12'd0);

  // Frame-level state: presses bump the pending mode, the frame tick
  // publishes the old pending value and moves the box one step.
  always_comb begin
    pending_d = pending_q;
    mode_d    = mode_q;
    box_x_d   = box_x_q;
    box_y_d   = box_y_q;
    box_dx_d  = box_dx_q;
    box_dy_d  = box_dy_q;
    if (press) begin
      pending_d = mode_e'(pending_q + 2'd1);
    end
    if (frame_tick) begin
      mode_d              = pending_q;
      {box_dx_d, box_x_d} = bounce_step(box_x_q, box_dx_q, BOX_X_MAX);
      {box_dy_d, box_y_d} = bounce_step(box_y_q, box_dy_q, BOX_Y_MAX);
    end
  end

  // S1: active-window decode and pixel coordinates
  always_comb begin
    s1_active_d = (I_hor_cnt >= H_FIRST) && (I_hor_cnt <= H_LAST) &&
                  (I_ver_cnt >= V_FIRST) && (I_ver_cnt <= V_LAST);
    s1_x_d      = 11'(I_hor_cnt - H_FIRST);
    s1_y_d      = 11'(I_ver_cnt - V_FIRST);
  end

  // S2: all four patterns in parallel; the mode travels with the pixel so
  // a frame tick switches pattern exactly at the first pixel of the frame
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (s1_x_q >= 11'(i * BAR_W)) bar_idx = 3'(i);
    end
    in_box_x = (s1_x_q >= box_x_q) &&
               ({1'b0, s1_x_q} < ({1'b0, box_x_q} + BOX_LEN));
    in_box_y = (s1_y_q >= box_y_q) &&
               ({1'b0, s1_y_q} < ({1'b0, box_y_q} + BOX_LEN));
    s2_bars_d   = bar_color(bar_idx);
    s2_grad_d   = {GRAD_B, s1_y_q[7:0], s1_x_q[7:0]};
    s2_check_d  = (s1_x_q[5] ^ s1_y_q[5]) ? COLOR_WHITE : COLOR_BLACK;
    s2_box_d    = (in_box_x && in_box_y) ? BOX_FG : BOX_BG;
    s2_active_d = s1_active_q;
    s2_mode_d   = mode_q;
`ifdef PATTERN_GEN_BORDER_EN
    s2_edge_d   = (s1_x_q == 11'd0) || (s1_x_q == 11'(H_RES - 1)) ||
                  (s1_y_q == 11'd0) || (s1_y_q == 11'(V_RES - 1));
`endif
  end

  // S3 select with blanking outside the active window, then S4 output
  always_comb begin
    s3_color_d = COLOR_BLACK;
    case (s2_mode_q)
      MODE_BARS:  s3_color_d = s2_bars_q;
      MODE_GRAD:  s3_color_d = s2_grad_q;
      MODE_CHECK: s3_color_d = s2_check_q;
      MODE_BOX:   s3_color_d = s2_box_q;
      default:    s3_color_d = COLOR_BLACK;
    endcase
    if (!s2_active_q) s3_color_d = COLOR_BLACK;
`ifdef PATTERN_GEN_BORDER_EN
    if (s2_active_q && s2_edge_q) s3_color_d = COLOR_WHITE;
`endif
    out_color_d = s3_color_q;
  end

  // All registers; reset flushes the pipeline and restarts the box
  always_ff @(posedge pix_clk or negedge hdmi4_rst_n) begin
    if (!hdmi4_rst_n) begin
      mode_q      <= MODE_BARS;
      pending_q   <= MODE_BARS;
      box_x_q     <= '0;
      box_y_q     <= '0;
      box_dx_q    <= 1'b1;
      box_dy_q    <= 1'b1;
      s1_active_q <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s2_bars_q   <= '0;
      s2_grad_q   <= '0;
      s2_check_q  <= '0;
      s2_box_q    <= '0;
      s2_active_q <= 1'b0;
      s2_mode_q   <= MODE_BARS;
`ifdef PATTERN_GEN_BORDER_EN
      s2_edge_q   <= 1'b0;
`endif
      s3_color_q  <= '0;
      out_color_q <= '0;
    end else begin
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      box_dx_q    <= box_dx_d;
      box_dy_q    <= box_dy_d;
      s1_active_q <= s1_active_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s2_bars_q   <= s2_bars_d;
      s2_grad_q   <= s2_grad_d;
      s2_check_q  <= s2_check_d;
      s2_box_q    <= s2_box_d;
      s2_active_q <= s2_active_d;
      s2_mode_q   <= s2_mode_d;
`ifdef PATTERN_GEN_BORDER_EN
      s2_edge_q   <= s2_edge_d;
`endif
      s3_color_q  <= s3_color_d;
      out_color_q <= out_color_d;
    end
  end

  assign O_color = out_color_q;
  assign O_mode  = mode_q;

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed and random stimulus for pattern_gen, checked every
// cycle against a frame/pixel-level model, plus literal pixel expectations.
module tb_pattern_gen;

  localparam int DB = 16;

  logic        pix_clk     = 1'b0;
  logic        hdmi4_rst_n = 1'b1;
  logic [11:0] hor         = 12'd5;
  logic [11:0] ver         = 12'd5;
  logic        btn_n       = 1'b1;
  logic [23:0] O_color;
  logic [1:0]  O_mode;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  pattern_gen #(.DEBOUNCE_CYCLES(DB)) dut (
    .pix_clk    (pix_clk),
    .hdmi4_rst_n(hdmi4_rst_n),
    .I_hor_cnt  (hor),
    .I_ver_cnt  (ver),
    .I_btn_n    (btn_n),
    .O_color    (O_color),
    .O_mode     (O_mode)
  );

  always #5 pix_clk = ~pix_clk;

  // Model state: frame-level quantities only
  int          m_mode, m_pend, m_bx, m_by, m_dx, m_dy;
  bit          m_db, m_press;
  bit          hist[DB+2];
  logic [23:0] exp_q[$];
  logic [23:0] exp_now;
  logic [23:0] bars[8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                           24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

  // Colour of a screen position from the pattern definitions
  function automatic logic [23:0] pixColour(int h, int v, int mode, int bx, int by);
    int x, y;
    x = h - 260;
    y = v - 25;
    if (x < 0 || x >= 1280 || y < 0 || y >= 720) return 24'h0;
    case (mode)
      0: return bars[x / 160];
      1: return 24'(32'h800000 + (y % 256) * 256 + (x % 256));
      2: return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
      default: return (x >= bx && x < bx + 64 && y >= by && y < by + 64) ? 24'hFFFFFF : 24'h400000;
    endcase
  endfunction

  function automatic void stepAxis(inout int pos, inout int dir, input int lim);
    if (dir > 0 && pos == lim) dir = -1;
    else if (dir < 0 && pos == 0) dir = 1;
    pos = pos + dir;
  endfunction

  task automatic modelReset();
    m_mode = 0; m_pend = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    m_db = 1'b1; m_press = 1'b0;
    foreach (hist[k]) hist[k] = 1'b1;
    exp_q = '{24'h0, 24'h0, 24'h0};
    exp_now = 24'h0;
  endtask

  // Model: a button level is accepted once DB consecutive raw samples agree
  // (seen through two sync stages); the press then counts one cycle later.
  initial begin
    bit allsame;
    bit press_now;
    wait (hdmi4_rst_n == 1'b0);
    modelReset();
    forever begin
      @(posedge pix_clk or negedge hdmi4_rst_n);
      if (!hdmi4_rst_n) begin
        modelReset();
      end else begin
        if (hor == 12'd0 && ver == 12'd0) begin
          m_mode = m_pend;
          stepAxis(m_bx, m_dx, 1280 - 64);
          stepAxis(m_by, m_dy, 720 - 64);
        end
        if (m_press) m_pend = (m_pend + 1) % 4;
        for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = btn_n;
        allsame = 1'b1;
        for (int k = 2; k <= DB + 1; k++) if (hist[k] != hist[2]) allsame = 1'b0;
        press_now = 1'b0;
        if (allsame && hist[2] != m_db) begin
          m_db = hist[2];
          if (!m_db) press_now = 1'b1;
        end
        m_press = press_now;
        exp_q.push_back(pixColour(int'(hor), int'(ver), m_mode, m_bx, m_by));
        exp_now = exp_q.pop_front();
      end
    end
  end

  task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge pix_clk);
      if (cmp_en) begin
        checkOutput("model_color", O_color, exp_now);
        checkOutput("model_mode", 24'(O_mode), 24'(m_mode));
      end
    end
  end

  // Drive one cycle of counters/button starting at a falling edge
  task automatic applyStimulus(input int h, input int v, input logic b);
    hor   = 12'(h);
    ver   = 12'(v);
    btn_n = b;
    @(negedge pix_clk);
  endtask

  task automatic pixelCheck(input int h, input int v, input logic [23:0] exp, input string name);
    applyStimulus(h, v, btn_n);
    repeat (3) applyStimulus(5, 5, btn_n);
    checkOutput(name, O_color, exp);
  endtask

  task automatic cleanPress();
    repeat (40) applyStimulus(5, 5, 1'b0);
    repeat (40) applyStimulus(5, 5, 1'b1);
  endtask

  task automatic bouncyPress();
    repeat (5) begin
      repeat (3) applyStimulus(5, 5, 1'b0);
      repeat (2) applyStimulus(5, 5, 1'b1);
    end
    repeat (40) applyStimulus(5, 5, 1'b0);
    repeat (5) begin
      repeat (2) applyStimulus(5, 5, 1'b1);
      repeat (3) applyStimulus(5, 5, 1'b0);
    end
    repeat (40) applyStimulus(5, 5, 1'b1);
  endtask

  task automatic pulseReset();
    #3 hdmi4_rst_n = 1'b0;
    #1;
    checkOutput("async_rst_color", O_color, 24'h0);
    checkOutput("async_rst_mode", 24'(O_mode), 24'h0);
    @(negedge pix_clk);
    @(negedge pix_clk);
    hdmi4_rst_n = 1'b1;
  endtask

  initial begin
    int h, v, r;
    logic b;
    #2 hdmi4_rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge pix_clk);
    checkOutput("reset_color", O_color, 24'h0);
    checkOutput("reset_mode", 24'(O_mode), 24'h0);
    hdmi4_rst_n = 1'b1;

    $display("[TB] bars mode pixels");
    pixelCheck(260, 25, 24'hFFFFFF, "bar_white_first");
    pixelCheck(420, 25, 24'h00FFFF, "bar_yellow");
    pixelCheck(259, 25, 24'h000000, "pre_active");
    pixelCheck(1539, 744, 24'h000000, "bar_black_last");

    $display("[TB] bouncy press and frame-start mode change");
    bouncyPress();
    checkOutput("mode_before_tick", 24'(O_mode), 24'h0);
    applyStimulus(0, 0, 1'b1);
    checkOutput("mode_after_tick", 24'(O_mode), 24'h1);
    pixelCheck(260 + 'h1A5, 25 + 'h33, 24'h8033A5, "gradient");

    $display("[TB] bouncing box after 1217 frames");
    pulseReset();
    repeat (3) cleanPress();
    repeat (1217) begin
      applyStimulus(0, 0, 1'b1);
      applyStimulus(5, 5, 1'b1);
    end
    checkOutput("box_mode", 24'(O_mode), 24'h3);
    pixelCheck(1475, 120, 24'hFFFFFF, "box_left_edge_in");
    pixelCheck(1474, 120, 24'h400000, "box_left_outside");
    pixelCheck(1538, 120, 24'hFFFFFF, "box_right_edge_in");
    pixelCheck(1539, 120, 24'h400000, "box_right_outside");

    $display("[TB] press coincident with frame tick");
    repeat (DB + 2) applyStimulus(5, 5, 1'b0);
    applyStimulus(0, 0, 1'b0);
    checkOutput("coincident_mode", 24'(O_mode), 24'h3);
    repeat (30) applyStimulus(5, 5, 1'b0);
    repeat (40) applyStimulus(5, 5, 1'b1);
    applyStimulus(0, 0, 1'b1);
    checkOutput("wrapped_mode", 24'(O_mode), 24'h0);

    $display("[TB] reset mid-line in checker mode");
    cleanPress();
    cleanPress();
    applyStimulus(0, 0, 1'b1);
    checkOutput("checker_mode", 24'(O_mode), 24'h2);
    for (int i = 0; i < 8; i++) applyStimulus(262 + i, 57, 1'b1);
    checkOutput("checker_pixel", O_color, 24'hFFFFFF);
    pulseReset();
    pixelCheck(260, 25, 24'hFFFFFF, "post_reset_first");

    $display("[TB] random stimulus");
    b = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        h = 0; v = 0;
      end else if (r < 80) begin
        h = int'($urandom_range(250, 1545));
        v = int'($urandom_range(20, 750));
      end else begin
        h = int'($urandom_range(0, 1649));
        v = int'($urandom_range(0, 749));
      end
      if ($urandom_range(0, 29) == 0) b = ~b;
      applyStimulus(h, v, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
